mod_exp_engine: RTL and testbench



---
 rtl/mod_exp_pkg.sv | 23 ++
 rtl/mod_mul_serial.sv | 97 +++++++++
 rtl/mod_exp_engine.sv | 129 ++++++++++++
 tb/tb_mod_exp_engine.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mod_exp_pkg.sv
// mod_exp_pkg
//   Shared definitions for the modular exponentiation engine and its
//   bit-serial modular multiplier.
//   - WIDTH_DEFAULT : default operand width in bits
//   - state_t       : exponentiation FSM states
//   - mstate_t      : multiplier states
package mod_exp_pkg;

   localparam int unsigned WIDTH_DEFAULT = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SQR  = 2'd1,
      MUL  = 2'd2,
      DONE = 2'd3
   } state_t;

   typedef enum logic {
      M_IDLE = 1'b0,
      M_RUN  = 1'b1
   } mstate_t;

endpackage

// File: rtl/mod_mul_serial.sv
// mod_mul_serial
//   Bit-serial modular multiplier: p = a*b mod n, for a,b < n.
//   Scans a MSB-first, one bit per cycle, with a fixed WIDTH-cycle latency.
//   The cycle that carries go already processes a's top bit, and rdy is
//   raised during the cycle that processes a's last bit, so a back-to-back
//   go can follow in the very next cycle.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     go       : launch pulse, honoured only while idle; a, b, n sampled then
//     a, b, n  : multiplicand, multiplier, modulus
//     p        : product, valid while rdy is high
//     rdy      : one-cycle completion pulse
module mod_mul_serial
   import mod_exp_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             go,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] n,
   output logic [WIDTH-1:0] p,
   output logic             rdy
);

   localparam int unsigned KW = (WIDTH > 2) ? $clog2(WIDTH - 1) : 1;

   mstate_t          mstate;
   logic [KW-1:0]    k;
   logic [WIDTH-1:0] a_q, b_q, n_q, r_q;

   logic [WIDTH-1:0] r_in, a_cur, b_cur, n_cur;
   logic [WIDTH:0]   n_ext, dbl, sum;
   logic [WIDTH-1:0] r_dbl, r_new;

   // In the go cycle the live inputs feed the datapath directly.
   // Every sum and compare is WIDTH+1 bits wide, so nothing overflows
   // even when n = 2^WIDTH-1.
   always_comb begin
      if (mstate == M_IDLE) begin
         r_in  = '0;
         a_cur = a;
         b_cur = b;
         n_cur = n;
      end else begin
         r_in  = r_q;
         a_cur = a_q;
         b_cur = b_q;
         n_cur = n_q;
      end
      n_ext = {1'b0, n_cur};
      dbl   = {r_in, 1'b0};
      r_dbl = (dbl >= n_ext) ? (dbl[WIDTH-1:0] - n_cur) : dbl[WIDTH-1:0];
      sum   = {1'b0, r_dbl} + (a_cur[WIDTH-1] ? {1'b0, b_cur} : '0);
      r_new = (sum >= n_ext) ? (sum[WIDTH-1:0] - n_cur) : sum[WIDTH-1:0];
   end

   assign p   = r_new;
   assign rdy = (mstate == M_RUN) && (k == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mstate <= M_IDLE;
         k      <= '0;
         a_q    <= '0;
         b_q    <= '0;
         n_q    <= '0;
         r_q    <= '0;
      end else begin
         case (mstate)
            M_IDLE: begin
               if (go) begin
                  r_q    <= r_new;
                  a_q    <= {a[WIDTH-2:0], 1'b0};
                  b_q    <= b;
                  n_q    <= n;
                  k      <= KW'(WIDTH - 2);
                  mstate <= M_RUN;
               end
            end
            M_RUN: begin
               r_q <= r_new;
               a_q <= {a_q[WIDTH-2:0], 1'b0};
               if (k == '0) begin
                  mstate <= M_IDLE;
               end else begin
                  k <= k - 1'b1;
               end
            end
            default: mstate <= M_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/mod_exp_engine.sv
// mod_exp_engine
//   result = base^exponent mod modulus by left-to-right square-and-multiply
//   over one shared bit-serial modular multiplier. All WIDTH squarings are
//   always performed, so latency depends only on popcount(exponent).
//   Ports:
//     clk, rst  : clock, asynchronous active-high reset
//     start     : request, sampled only while busy = 0
//     base      : base, must be < modulus
//     exponent  : exponent
//     modulus   : modulus, must be >= 2
//     result    : base^exponent mod modulus (0 on error), held until next start
//     busy      : operation in progress
//     done      : one-cycle completion pulse
//     err       : operand error, valid with done, held until next start
module mod_exp_engine
   import mod_exp_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] base,
   input  logic [WIDTH-1:0] exponent,
   input  logic [WIDTH-1:0] modulus,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int unsigned IW = $clog2(WIDTH);

   state_t           state;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] acc, base_q, exp_q, n_q;
   logic             go_q;

   logic [WIDTH-1:0] mul_b, mul_p;
   logic             mul_rdy;

   assign mul_b = (state == MUL) ? base_q : acc;

   mod_mul_serial #(.WIDTH(WIDTH)) u_mul (
      .clk (clk),
      .rst (rst),
      .go  (go_q),
      .a   (acc),
      .b   (mul_b),
      .n   (n_q),
      .p   (mul_p),
      .rdy (mul_rdy)
   );

   always_comb begin
      busy = (state == SQR) || (state == MUL);
      done = (state == DONE);
   end

   // go_q is raised on every entry into SQR/MUL so the next multiply starts
   // in the first cycle of that state; the "next bit" step is folded into
   // the multiplier's completing cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         idx    <= '0;
         acc    <= '0;
         base_q <= '0;
         exp_q  <= '0;
         n_q    <= '0;
         go_q   <= 1'b0;
         result <= '0;
         err    <= 1'b0;
      end else begin
         go_q <= 1'b0;
         case (state)
            IDLE, DONE: begin
               state <= IDLE;
               if (start) begin
                  base_q <= base;
                  exp_q  <= exponent;
                  n_q    <= modulus;
                  err    <= 1'b0;
                  if ((modulus < WIDTH'(2)) || (base >= modulus)) begin
                     err    <= 1'b1;
                     result <= '0;
                     state  <= DONE;
                  end else begin
                     acc   <= WIDTH'(1);
                     idx   <= IW'(WIDTH - 1);
                     go_q  <= 1'b1;
                     state <= SQR;
                  end
               end
            end
            SQR: begin
               if (mul_rdy) begin
                  acc <= mul_p;
                  if (exp_q[idx]) begin
                     go_q  <= 1'b1;
                     state <= MUL;
                  end else if (idx == '0) begin
                     result <= mul_p;
                     state  <= DONE;
                  end else begin
                     idx  <= idx - 1'b1;
                     go_q <= 1'b1;
                  end
               end
            end
            MUL: begin
               if (mul_rdy) begin
                  acc <= mul_p;
                  if (idx == '0) begin
                     result <= mul_p;
                     state  <= DONE;
                  end else begin
                     idx   <= idx - 1'b1;
                     go_q  <= 1'b1;
                     state <= SQR;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mod_exp_engine.sv
module tb_mod_exp_engine;

   localparam int W = 64;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] base = '0;
   logic [W-1:0] exponent = '0;
   logic [W-1:0] modulus = '0;
   logic [W-1:0] result;
   logic         busy, done, err;

   int checks = 0;
   int errors = 0;

   mod_exp_engine #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .base     (base),
      .exponent (exponent),
      .modulus  (modulus),
      .result   (result),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic [W-1:0] b;
      logic [W-1:0] e;
      logic [W-1:0] n;
      logic [W-1:0] res;
      logic         er;
   } vec_t;

   // Reference: right-to-left binary exponentiation with 128-bit arithmetic.
   function automatic logic [W-1:0] ref_modexp(logic [W-1:0] b, logic [W-1:0] e,
                                               logic [W-1:0] n);
      logic [2*W-1:0] r, x, nn;
      logic [W-1:0]   ee;
      if (n < 2 || b >= n) return '0;
      nn = {{W{1'b0}}, n};
      r  = 1;
      x  = {{W{1'b0}}, b};
      ee = e;
      while (ee != 0) begin
         if (ee[0]) r = (r * x) % nn;
         x  = (x * x) % nn;
         ee = ee >> 1;
      end
      return r[W-1:0];
   endfunction

   function automatic int exp_latency(logic [W-1:0] e, logic er);
      if (er) return 1;
      return 1 + W * (W + $countones(e));
   endfunction

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, expv);
      end
   endtask

   task automatic launch(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] n);
      @(negedge clk);
      base = b;
      exponent = e;
      modulus = n;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // c0 = cycle offset from acceptance already elapsed (1 right after launch)
   task automatic wait_done(input string nm, input logic [W-1:0] res, input logic er,
                            input int lat, input int c0);
      int c;
      logic [W-1:0] held;
      c = c0;
      while (done !== 1'b1 && c < lat + 20) begin
         @(posedge clk);
         #1;
         c++;
      end
      if (done !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: no done after %0d cycles, expected at %0d", nm, c, lat);
      end else begin
         chk({nm, " latency"}, W'(c), W'(lat));
         chk({nm, " result"}, result, res);
         chk({nm, " err"}, W'(err), W'(er));
         chk({nm, " busy@done"}, W'(busy), '0);
         held = result;
         @(posedge clk);
         #1;
         chk({nm, " done pulse width"}, W'(done), '0);
         chk({nm, " result held"}, result, held);
      end
   endtask

   task automatic run_op(input string nm, input logic [W-1:0] b, input logic [W-1:0] e,
                         input logic [W-1:0] n, input logic [W-1:0] res, input logic er);
      launch(b, e, n);
      wait_done(nm, res, er, exp_latency(e, er), 1);
   endtask

   vec_t vecs[$];

   initial begin
      logic [W-1:0] rb, re, rn;

      vecs.push_back('{"19^5 mod 119",    64'd19,  64'd5,  64'd119, 64'd66, 1'b0});
      vecs.push_back('{"66^77 mod 119",   64'd66,  64'd77, 64'd119, 64'd19, 1'b0});
      vecs.push_back('{"7^0 mod 119",     64'd7,   64'd0,  64'd119, 64'd1,  1'b0});
      vecs.push_back('{"0^9 mod 119",     64'd0,   64'd9,  64'd119, 64'd0,  1'b0});
      vecs.push_back('{"err mod=1",       64'd0,   64'd5,  64'd1,   64'd0,  1'b1});
      vecs.push_back('{"err mod=0",       64'd0,   64'd5,  64'd0,   64'd0,  1'b1});
      vecs.push_back('{"err base>=mod",   64'd120, 64'd5,  64'd119, 64'd0,  1'b1});
      vecs.push_back('{"wide carry",      64'hFFFF_FFFF_FFFF_FFFE, 64'd3,
                       64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0});

      repeat (3) @(posedge clk);
      #1;
      chk("reset result", result, '0);
      chk("reset busy", W'(busy), '0);
      chk("reset done", W'(done), '0);
      chk("reset err", W'(err), '0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         chk({vecs[i].name, " model"}, ref_modexp(vecs[i].b, vecs[i].e, vecs[i].n), vecs[i].res);
         run_op(vecs[i].name, vecs[i].b, vecs[i].e, vecs[i].n, vecs[i].res, vecs[i].er);
      end

      // start pulsed mid-operation with different operands is ignored
      launch(64'd19, 64'd5, 64'd119);
      for (int c = 0; c < 50; c++) begin
         if (c == 10) begin
            start = 1'b1;
            base = 64'd66;
            exponent = 64'd77;
            modulus = 64'd97;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      wait_done("overlap ignored", 64'd66, 1'b0, exp_latency(64'd5, 1'b0), 51);

      // reset mid-operation aborts immediately
      launch(64'd66, 64'd77, 64'd119);
      repeat (100) @(posedge clk);
      #1;
      chk("pre-abort busy", W'(busy), 64'd1);
      rst = 1'b1;
      #1;
      chk("abort busy", W'(busy), '0);
      chk("abort done", W'(done), '0);
      chk("abort result", result, '0);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("no done after abort", W'(done), '0);
      run_op("after reset 19^5", 64'd19, 64'd5, 64'd119, 64'd66, 1'b0);

      // randomized operands against the reference model
      for (int t = 0; t < 3; t++) begin
         rn = {$urandom(), $urandom()};
         if (rn < 2) rn = 64'd2;
         rb = {$urandom(), $urandom()} % rn;
         re = {$urandom(), $urandom()};
         run_op($sformatf("random %0d", t), rb, re, rn, ref_modexp(rb, re, rn), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
